// File: rtl/debounce_edge_capture.sv
// debounce_edge_capture: synchronized, debounced inputs with sticky edge capture, irq and optional auto-repeat (DBNC_AUTOREPEAT_EN)
module debounce_edge_capture #(
  parameter int N_CH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [N_CH-1:0] RESET_LEVEL = '1,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] raw_in,
  input  logic [1:0]      address,
  input  logic            read,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq,
  output logic [N_CH-1:0] level_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N_CH-1:0] s1, s2, db, db_q, edges, mask, sel, hit, rep, clr;
  logic [CW-1:0] cnt [N_CH];
  assign level_out = db;
  assign hit = (sel & db & ~db_q) | (~sel & ~db & db_q);
  assign clr = (write && address == 2'd1) ? writedata[N_CH-1:0] : '0;
  // two-flop synchronizer for the asynchronous raw levels
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  // per-channel stability counter; the debounced bit flips when the count would reach DEBOUNCE_CYCLES
  always_ff @(posedge clk)
    for (int i = 0; i < N_CH; i++)
      if (!reset_n) begin
        cnt[i] <= '0;
        db[i] <= RESET_LEVEL[i];
      end else if (s2[i] == db[i]) cnt[i] <= '0;
      else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt[i] <= '0;
        db[i] <= s2[i];
      end else cnt[i] <= cnt[i] + 1'b1;
  // register file, sticky edge capture (set beats clear), registered irq and read data
  always_ff @(posedge clk)
    if (!reset_n) begin
      db_q <= RESET_LEVEL;
      edges <= '0;
      mask <= '0;
      sel <= '0;
      irq <= 1'b0;
      readdata <= '0;
    end else begin
      db_q <= db;
      edges <= (edges & ~clr) | hit | rep;
      if (write && address == 2'd2) mask <= writedata[N_CH-1:0];
      if (write && address == 2'd3) sel <= writedata[N_CH-1:0];
      irq <= |(edges & mask);
      if (read) readdata <= address == 2'd0 ? 32'(db) : address == 2'd1 ? 32'(edges) : address == 2'd2 ? 32'(mask) : 32'(sel);
    end
`ifdef DBNC_AUTOREPEAT_EN
  localparam int RW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
  logic [N_CH-1:0] armed, held, active;
  logic [RW-1:0] rc [N_CH];
  assign active = ~(sel ^ db);
  for (genvar r = 0; r < N_CH; r++) begin : g_rep
    assign rep[r] = armed[r] & active[r] & (rc[r] == (held[r] ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1)));
  end
  // hold/repeat timer: armed by a captured edge, cleared whenever the channel leaves its active level
  always_ff @(posedge clk)
    for (int i = 0; i < N_CH; i++)
      if (!reset_n || !active[i]) begin
        armed[i] <= 1'b0;
        held[i] <= 1'b0;
        rc[i] <= '0;
      end else if (hit[i]) begin
        armed[i] <= 1'b1;
        held[i] <= 1'b0;
        rc[i] <= '0;
      end else if (rep[i]) begin
        held[i] <= 1'b1;
        rc[i] <= '0;
      end else if (armed[i]) rc[i] <= rc[i] + 1'b1;
`else
  assign rep = '0;
`endif
endmodule

// File: tb/tb_debounce_edge_capture.sv
// tb_debounce_edge_capture: random stimulus against a window-based reference model
module tb_debounce_edge_capture;
  localparam int D = 8, HOLD = 40, REP = 10;
  localparam logic [3:0] RL = 4'hF;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] raw_in = RL;
  logic [1:0] address = 2'd0;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  logic [3:0] level_out;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  debounce_edge_capture #(
    .N_CH(4), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .level_out(level_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  logic [3:0] m_db, m_edges, m_mask, m_sel, pend_r, pend_f;
  logic m_irq;
  logic [31:0] m_rd;
  logic [3:0] dq[$];
  logic [3:0] sq[$];
  bit arm[4];
  int cap[4];
  int cyc = 0;
  always @(posedge clk) begin
    logic [3:0] nd, hit, clr, rep;
    bit all_diff, act;
    int d;
    cyc++;
    if (!reset_n) begin
      dq.delete();
      dq.push_back(RL);
      dq.push_back(RL);
      sq.delete();
      m_db = RL;
      m_edges = '0;
      m_mask = '0;
      m_sel = '0;
      m_irq = 1'b0;
      m_rd = '0;
      pend_r = '0;
      pend_f = '0;
      for (int c = 0; c < 4; c++) arm[c] = 0;
    end else begin
      sq.push_back(dq.pop_front());
      dq.push_back(raw_in);
      if (sq.size() > D) void'(sq.pop_front());
      nd = m_db;
      for (int c = 0; c < 4; c++) begin
        all_diff = (sq.size() == D);
        foreach (sq[k]) if (sq[k][c] == m_db[c]) all_diff = 0;
        if (all_diff) nd[c] = ~m_db[c];
      end
      hit = (m_sel & pend_r) | (~m_sel & pend_f);
      rep = '0;
`ifdef DBNC_AUTOREPEAT_EN
      for (int c = 0; c < 4; c++) begin
        act = m_sel[c] ? m_db[c] : ~m_db[c];
        d = cyc - cap[c];
        if (!act) arm[c] = 0;
        else if (hit[c]) begin
          arm[c] = 1;
          cap[c] = cyc;
        end else if (arm[c] && d >= HOLD && (d - HOLD) % REP == 0) rep[c] = 1'b1;
      end
`endif
      clr = (write && address == 2'd1) ? writedata[3:0] : 4'h0;
      m_irq = |(m_edges & m_mask);
      if (read) m_rd = {28'h0, address == 2'd0 ? m_db : address == 2'd1 ? m_edges : address == 2'd2 ? m_mask : m_sel};
      m_edges = (m_edges & ~clr) | hit | rep;
      if (write && address == 2'd2) m_mask = writedata[3:0];
      if (write && address == 2'd3) m_sel = writedata[3:0];
      pend_r = nd & ~m_db;
      pend_f = ~nd & m_db;
      m_db = nd;
    end
  end
  initial begin
    int rem[4];
    int r;
    for (int c = 0; c < 4; c++) rem[c] = 30;
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      chk("level_out", 32'(level_out), 32'(m_db));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("readdata", readdata, m_rd);
      reset_n = (t >= 2) && ($urandom_range(0, 799) != 0);
      for (int c = 0; c < 4; c++)
        if (rem[c] == 0) begin
          raw_in[c] = ~raw_in[c];
          rem[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(9, 90) : $urandom_range(1, 12);
        end else rem[c]--;
      r = $urandom_range(0, 9);
      read = (r < 3);
      write = (r == 3 || r == 4);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
